// File: rtl/mem_stage.sv
// MEM stage of the in-order pipeline: waits for the data-SRAM response, aligns load data, hands off to WB.
// Optional build macro MEM_FWD_EN enables forwarding of MEM results to ID.
module mem_stage #(
    parameter int DISCARD_W = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          es2ms_valid,
    output logic          ms_allowin,
    input  logic [154:0]  es2ms_bus,
    input  logic [38:0]   es_rf_zip,
    input  logic          data_sram_data_ok,
    input  logic [31:0]   data_sram_rdata,
    output logic          ms2ws_valid,
    input  logic          ws_allowin,
    output logic [148:0]  ms2ws_bus,
    output logic [38:0]   ms_rf_zip,
    output logic [38:0]   ms_fwd,
    input  logic          wb_ex,
    input  logic          ertn_flush,
    output logic          ms_ex
);

    logic                 ms_valid_q, ms_valid_d;
    logic [4:0]           ld_op_q;
    logic                 mem_req_q;
    logic [31:0]          vaddr_q;
    logic [31:0]          pc_q;
    logic [84:0]          except_q;
    logic                 csr_re_q;
    logic                 rf_we_q;
    logic [4:0]           rf_waddr_q;
    logic [31:0]          alu_result_q;
    logic                 rdbuf_valid_q, rdbuf_valid_d;
    logic [31:0]          rdbuf_data_q, rdbuf_data_d;
    logic [DISCARD_W-1:0] discard_cnt_q, discard_cnt_d;

    logic flush, cnt_zero, live_ok, got_resp, waiting, ms_ready_go;
    logic accept, handoff, cnt_inc, cnt_dec;
    logic [31:0] rdata_sel, ld_result, final_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        fwd_block, fwd_we;
    logic [31:0] fwd_wdata;

    assign flush       = wb_ex | ertn_flush;
    assign cnt_zero    = (discard_cnt_q == '0);
    // A response only belongs to the current instruction once all stale ones are drained
    assign live_ok     = data_sram_data_ok & cnt_zero;
    assign got_resp    = rdbuf_valid_q | live_ok;
    assign waiting     = ms_valid_q & mem_req_q & ~got_resp;
    assign ms_ready_go = ~mem_req_q | got_resp;
    assign ms_allowin  = ~ms_valid_q | (ms_ready_go & ws_allowin);
    assign ms2ws_valid = ms_valid_q & ms_ready_go;
    assign accept      = es2ms_valid & ms_allowin & ~flush;
    assign handoff     = ms2ws_valid & ws_allowin;
    assign cnt_inc     = flush & waiting;
    assign cnt_dec     = data_sram_data_ok & ~cnt_zero;

    always_comb begin
        ms_valid_d = ms_valid_q;
        if (flush) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es2ms_valid;
        end
    end

    always_comb begin
        rdbuf_valid_d = rdbuf_valid_q;
        rdbuf_data_d  = rdbuf_data_q;
        if (flush || handoff) begin
            rdbuf_valid_d = 1'b0;
        end else if (live_ok && ms_valid_q && mem_req_q && !ws_allowin && !rdbuf_valid_q) begin
            rdbuf_valid_d = 1'b1;
            rdbuf_data_d  = data_sram_rdata;
        end
    end

    always_comb begin
        discard_cnt_d = discard_cnt_q;
        if (cnt_inc && !cnt_dec) begin
            discard_cnt_d = discard_cnt_q + DISCARD_W'(1);
        end else if (cnt_dec && !cnt_inc) begin
            discard_cnt_d = discard_cnt_q - DISCARD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid_q    <= 1'b0;
            ld_op_q       <= '0;
            mem_req_q     <= 1'b0;
            vaddr_q       <= '0;
            pc_q          <= '0;
            except_q      <= '0;
            csr_re_q      <= 1'b0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            alu_result_q  <= '0;
            rdbuf_valid_q <= 1'b0;
            rdbuf_data_q  <= '0;
            discard_cnt_q <= '0;
        end else begin
            ms_valid_q    <= ms_valid_d;
            rdbuf_valid_q <= rdbuf_valid_d;
            rdbuf_data_q  <= rdbuf_data_d;
            discard_cnt_q <= discard_cnt_d;
            if (accept) begin
                {ld_op_q, mem_req_q, vaddr_q, pc_q, except_q}   <= es2ms_bus;
                {csr_re_q, rf_we_q, rf_waddr_q, alu_result_q}   <= es_rf_zip;
            end
        end
    end

    assign rdata_sel = rdbuf_valid_q ? rdbuf_data_q : data_sram_rdata;

    always_comb begin
        ld_byte = rdata_sel[7:0];
        unique case (vaddr_q[1:0])
            2'd1:    ld_byte = rdata_sel[15:8];
            2'd2:    ld_byte = rdata_sel[23:16];
            2'd3:    ld_byte = rdata_sel[31:24];
            default: ld_byte = rdata_sel[7:0];
        endcase
    end

    // Misaligned halfwords never get here: EX raises ALE and drops mem_req
    assign ld_half = vaddr_q[1] ? rdata_sel[31:16] : rdata_sel[15:0];

    always_comb begin
        ld_result = 32'h0;
        if (ld_op_q[4]) begin
            ld_result = {{24{ld_byte[7]}}, ld_byte};
        end else if (ld_op_q[3]) begin
            ld_result = {{16{ld_half[15]}}, ld_half};
        end else if (ld_op_q[2]) begin
            ld_result = rdata_sel;
        end else if (ld_op_q[1]) begin
            ld_result = {24'h0, ld_byte};
        end else if (ld_op_q[0]) begin
            ld_result = {16'h0, ld_half};
        end
    end

    assign final_wdata = (|ld_op_q) ? ld_result : alu_result_q;

    assign ms_ex     = ms_valid_q & (|except_q[6:0]);
    assign ms2ws_bus = {vaddr_q, pc_q, except_q};
    assign ms_rf_zip = {csr_re_q, rf_we_q & ms_valid_q, rf_waddr_q, final_wdata};

`ifdef MEM_FWD_EN
    assign fwd_we    = ms_valid_q & rf_we_q & ~ms_ex;
    assign fwd_block = ms_valid_q & (csr_re_q | ((|ld_op_q) & ~got_resp));
    assign fwd_wdata = final_wdata;
`else
    // Without forwarding, ID has to stall on any write pending in MEM
    assign fwd_we    = 1'b0;
    assign fwd_block = ms_valid_q & rf_we_q;
    assign fwd_wdata = 32'h0;
`endif

    assign ms_fwd = {fwd_block, fwd_we, rf_waddr_q, fwd_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed loads/ALU ops, buffered responses, flush discard and reset.
module tb_mem_stage;

    logic          clk = 1'b0;
    logic          resetn;
    logic          es2ms_valid;
    logic          ms_allowin;
    logic [154:0]  es2ms_bus;
    logic [38:0]   es_rf_zip;
    logic          data_sram_data_ok;
    logic [31:0]   data_sram_rdata;
    logic          ms2ws_valid;
    logic          ws_allowin;
    logic [148:0]  ms2ws_bus;
    logic [38:0]   ms_rf_zip;
    logic [38:0]   ms_fwd;
    logic          wb_ex;
    logic          ertn_flush;
    logic          ms_ex;

    int checks = 0;
    int errors = 0;
    logic [187:0] exp_q[$];
    logic [187:0] mon_exp;

    localparam logic [4:0] LD_B  = 5'b10000;
    localparam logic [4:0] LD_H  = 5'b01000;
    localparam logic [4:0] LD_W  = 5'b00100;
    localparam logic [4:0] LD_BU = 5'b00010;
    localparam logic [4:0] NOLD  = 5'b00000;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .es2ms_valid       (es2ms_valid),
        .ms_allowin        (ms_allowin),
        .es2ms_bus         (es2ms_bus),
        .es_rf_zip         (es_rf_zip),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms2ws_valid       (ms2ws_valid),
        .ws_allowin        (ws_allowin),
        .ms2ws_bus         (ms2ws_bus),
        .ms_rf_zip         (ms_rf_zip),
        .ms_fwd            (ms_fwd),
        .wb_ex             (wb_ex),
        .ertn_flush        (ertn_flush),
        .ms_ex             (ms_ex)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (resetn) assert (int'(dut.discard_cnt_q) <= 3);
    end

    // Monitor: every WB handoff must match the oldest expected instruction
    always @(negedge clk) begin
        if (resetn && ms2ws_valid && ws_allowin) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL handoff_unexpected: got %h, required no handoff", {ms2ws_bus, ms_rf_zip});
            end else begin
                mon_exp = exp_q.pop_front();
                if ({ms2ws_bus, ms_rf_zip} !== mon_exp) begin
                    errors++;
                    $display("FAIL handoff_data: got %h, required %h", {ms2ws_bus, ms_rf_zip}, mon_exp);
                end
            end
        end
    end

    function automatic logic [154:0] mk_bus(input logic [4:0] ld, input logic mr,
                                            input logic [31:0] va, input logic [31:0] pc,
                                            input logic [84:0] ex);
        return {ld, mr, va, pc, ex};
    endfunction

    function automatic logic [38:0] mk_rf(input logic csr, input logic we,
                                          input logic [4:0] wa, input logic [31:0] res);
        return {csr, we, wa, res};
    endfunction

    function automatic logic [187:0] mk_exp(input logic [31:0] va, input logic [31:0] pc,
                                            input logic [84:0] ex, input logic csr, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wdata);
        return {va, pc, ex, csr, we, wa, wdata};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [154:0] bus, input logic [38:0] rf);
        logic ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        es2ms_valid = 1'b1;
        es2ms_bus   = bus;
        es_rf_zip   = rf;
        while (!ok && n < 20) begin
            @(negedge clk);
            ok = ms_allowin;
            tick();
            n++;
        end
        es2ms_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ms_allowin 0 for 20 cycles, required 1");
        end
    endtask

    initial begin
        resetn            = 1'b0;
        es2ms_valid       = 1'b0;
        es2ms_bus         = '0;
        es_rf_zip         = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        ws_allowin        = 1'b1;
        wb_ex             = 1'b0;
        ertn_flush        = 1'b0;
        repeat (3) tick();
        chk("rst_ms2ws_valid", 64'(ms2ws_valid), 64'd0);
        chk("rst_ms_ex",       64'(ms_ex),       64'd0);
        chk("rst_ms_fwd",      64'(ms_fwd),      64'd0);
        chk("rst_allowin",     64'(ms_allowin),  64'd1);
        resetn = 1'b1;
        tick();

        // ALU op completes the cycle after accept
        exp_q.push_back(mk_exp(32'h0, 32'h1c00_0000, 85'h0, 1'b0, 1'b1, 5'd5, 32'h0000_1234));
        send(mk_bus(NOLD, 1'b0, 32'h0, 32'h1c00_0000, 85'h0), mk_rf(1'b0, 1'b1, 5'd5, 32'h1234));
        chk("alu_valid", 64'(ms2ws_valid), 64'd1);
`ifdef MEM_FWD_EN
        chk("alu_fwd", 64'(ms_fwd), 64'({1'b0, 1'b1, 5'd5, 32'h1234}));
`else
        chk("alu_fwd", 64'(ms_fwd), 64'({1'b1, 1'b0, 5'd5, 32'h0}));
`endif
        tick();

        // ld.b at offset 3, response two cycles late
        exp_q.push_back(mk_exp(32'h1000_0003, 32'h1c00_0004, 85'h0, 1'b0, 1'b1, 5'd6, 32'hFFFF_FF80));
        send(mk_bus(LD_B, 1'b1, 32'h1000_0003, 32'h1c00_0004, 85'h0), mk_rf(1'b0, 1'b1, 5'd6, 32'h1000_0003));
        chk("ldb_wait1", 64'(ms2ws_valid), 64'd0);
        tick();
        chk("ldb_wait2", 64'(ms2ws_valid), 64'd0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_0000;
        #1;
        chk("ldb_done", 64'(ms2ws_valid), 64'd1);
        tick();
        data_sram_data_ok = 1'b0;

        // ld.bu same data
        exp_q.push_back(mk_exp(32'h1000_0003, 32'h1c00_0008, 85'h0, 1'b0, 1'b1, 5'd7, 32'h0000_0080));
        send(mk_bus(LD_BU, 1'b1, 32'h1000_0003, 32'h1c00_0008, 85'h0), mk_rf(1'b0, 1'b1, 5'd7, 32'h1000_0003));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_0000;
        tick();
        data_sram_data_ok = 1'b0;

        // ld.h upper half, WB stalled: response must be buffered
        ws_allowin = 1'b0;
        exp_q.push_back(mk_exp(32'h2000_0002, 32'h1c00_000c, 85'h0, 1'b0, 1'b1, 5'd8, 32'hFFFF_8001));
        send(mk_bus(LD_H, 1'b1, 32'h2000_0002, 32'h1c00_000c, 85'h0), mk_rf(1'b0, 1'b1, 5'd8, 32'h2000_0002));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8001_1234;
        #1;
        chk("ldh_live_valid", 64'(ms2ws_valid), 64'd1);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hAAAA_5555;
        #1;
        chk("ldh_rdbuf_wdata", 64'(ms_rf_zip[31:0]), 64'h0000_0000_FFFF_8001);
        tick();
        tick();
        ws_allowin = 1'b1;
        tick();
        exp_q.push_back(mk_exp(32'h2000_0004, 32'h1c00_0010, 85'h0, 1'b0, 1'b1, 5'd9, 32'h1122_3344));
        send(mk_bus(LD_W, 1'b1, 32'h2000_0004, 32'h1c00_0010, 85'h0), mk_rf(1'b0, 1'b1, 5'd9, 32'h2000_0004));
        chk("rdbuf_not_reused", 64'(ms2ws_valid), 64'd0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1122_3344;
        tick();
        data_sram_data_ok = 1'b0;

        // Flush while waiting leaves one stale response to drop
        send(mk_bus(LD_W, 1'b1, 32'h3000_0000, 32'h1c00_0014, 85'h0), mk_rf(1'b0, 1'b1, 5'd10, 32'h3000_0000));
        wb_ex = 1'b1;
        tick();
        wb_ex = 1'b0;
        chk("flush_valid", 64'(ms2ws_valid), 64'd0);
        chk("flush_allowin", 64'(ms_allowin), 64'd1);
        chk("flush_cnt", 64'(dut.discard_cnt_q), 64'd1);
        exp_q.push_back(mk_exp(32'h3000_0008, 32'h1c00_0018, 85'h0, 1'b0, 1'b1, 5'd11, 32'h0000_0042));
        send(mk_bus(LD_W, 1'b1, 32'h3000_0008, 32'h1c00_0018, 85'h0), mk_rf(1'b0, 1'b1, 5'd11, 32'h3000_0008));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_DEAD;
        #1;
        chk("stale_ignored", 64'(ms2ws_valid), 64'd0);
        tick();
        data_sram_rdata = 32'h0000_0042;
        #1;
        chk("fresh_valid", 64'(ms2ws_valid), 64'd1);
        chk("drain_cnt", 64'(dut.discard_cnt_q), 64'd0);
        tick();
        data_sram_data_ok = 1'b0;

        // SYSCALL exception: no memory access, completes immediately
        exp_q.push_back(mk_exp(32'h0, 32'h1c00_001c, 85'h4, 1'b0, 1'b1, 5'd12, 32'h0000_0055));
        send(mk_bus(NOLD, 1'b0, 32'h0, 32'h1c00_001c, 85'h4), mk_rf(1'b0, 1'b1, 5'd12, 32'h55));
        chk("sys_ms_ex", 64'(ms_ex), 64'd1);
        chk("sys_valid", 64'(ms2ws_valid), 64'd1);
        tick();
        chk("sys_ex_clear", 64'(ms_ex), 64'd0);

        // Two flushes build up two stale responses, then reset clears everything
        send(mk_bus(LD_W, 1'b1, 32'h4000_0000, 32'h1c00_0020, 85'h0), mk_rf(1'b0, 1'b1, 5'd13, 32'h0));
        wb_ex = 1'b1;
        tick();
        wb_ex = 1'b0;
        send(mk_bus(LD_W, 1'b1, 32'h4000_0004, 32'h1c00_0024, 85'h0), mk_rf(1'b0, 1'b1, 5'd14, 32'h0));
        ertn_flush = 1'b1;
        tick();
        ertn_flush = 1'b0;
        chk("two_flush_cnt", 64'(dut.discard_cnt_q), 64'd2);
        send(mk_bus(LD_W, 1'b1, 32'h4000_0008, 32'h1c00_0028, 85'h0), mk_rf(1'b0, 1'b1, 5'd15, 32'h0));
        chk("wait_before_rst", 64'(ms_allowin), 64'd0);
        resetn = 1'b0;
        tick();
        chk("rst2_valid", 64'(ms2ws_valid), 64'd0);
        chk("rst2_allowin", 64'(ms_allowin), 64'd1);
        chk("rst2_cnt", 64'(dut.discard_cnt_q), 64'd0);
        resetn = 1'b1;
        tick();

        // Plain op after reset still flows
        exp_q.push_back(mk_exp(32'h0, 32'h1c00_0030, 85'h0, 1'b0, 1'b1, 5'd1, 32'hCAFE_0001));
        send(mk_bus(NOLD, 1'b0, 32'h0, 32'h1c00_0030, 85'h0), mk_rf(1'b0, 1'b1, 5'd1, 32'hCAFE_0001));
        tick();
        tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
